seq_arith_logic_unit: RTL and testbench

- Parametrised, registered successor to the RAT CPU single-cycle ALU.
- Same 4-bit opcode map, with registered C/Z flags and a start/busy/done handshake.
- Opcode 1111 is a new multi-cycle unsigned multiply (shift-add) producing a double-width product.
- Sits between the register file and the flag/result writeback logic; the control unit sequences it through the handshake.

---
 rtl/seq_arith_logic_unit.sv | 176 +++++++++++++++++
 tb/tb_seq_arith_logic_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_arith_logic_unit.sv
// Registered RAT-style ALU with C/Z flags, a start/busy/done handshake and a
// multi-cycle shift-add unsigned multiply on opcode 4'b1111.
module seq_arith_logic_unit #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             ALU_START,
  input  logic [WIDTH-1:0] ALU_A,
  input  logic [WIDTH-1:0] ALU_B,
  input  logic [3:0]       ALU_SEL,
  input  logic             ALU_CIN,
  output logic             ALU_BUSY,
  output logic             ALU_DONE,
  output logic [WIDTH-1:0] ALU_RESULT,
  output logic [WIDTH-1:0] ALU_RESULT_HI,
  output logic             ALU_C,
  output logic             ALU_Z
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_ADDC = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_SUBC = 4'b0011;
  localparam logic [3:0] OP_CMP  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_EXOR = 4'b0111;
  localparam logic [3:0] OP_TEST = 4'b1000;
  localparam logic [3:0] OP_LSL  = 4'b1001;
  localparam logic [3:0] OP_LSR  = 4'b1010;
  localparam logic [3:0] OP_ROL  = 4'b1011;
  localparam logic [3:0] OP_ROR  = 4'b1100;
  localparam logic [3:0] OP_ASR  = 4'b1101;
  localparam logic [3:0] OP_MOV  = 4'b1110;
  localparam logic [3:0] OP_MUL  = 4'b1111;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [WIDTH-1:0]     result_hi_q, result_hi_d;
  logic                 c_q, c_d;
  logic                 z_q, z_d;
  logic                 done_q, done_d;

  logic                 accept;
  logic [WIDTH:0]       alu_r;
  logic [2*WIDTH-1:0]   acc_nxt;

  // Single-cycle ops evaluated in WIDTH+1 bits; bit WIDTH is the carry/borrow.
  function automatic logic [WIDTH:0] alu_calc(
    input logic [3:0]       sel,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             cin
  );
    logic [WIDTH:0] r;
    r = '0;
    case (sel)
      OP_ADD:          r = {1'b0, a} + {1'b0, b};
      OP_ADDC:         r = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      OP_SUB, OP_CMP:  r = {1'b0, a} - {1'b0, b};
      OP_SUBC:         r = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
      OP_AND, OP_TEST: r = {1'b0, a & b};
      OP_OR:           r = {1'b0, a | b};
      OP_EXOR:         r = {1'b0, a ^ b};
      OP_LSL:          r = {a, cin};
      OP_LSR:          r = {a[0], cin, a[WIDTH-1:1]};
      OP_ROL:          r = {a[WIDTH-1], a[WIDTH-2:0], a[WIDTH-1]};
      OP_ROR:          r = {a[0], a[0], a[WIDTH-1:1]};
      OP_ASR:          r = {a[0], a[WIDTH-1], a[WIDTH-1:1]};
      OP_MOV:          r = {cin, b};
      default:         r = '0;
    endcase
    return r;
  endfunction

  assign accept = ALU_START && (state_q == S_IDLE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    c_d         = c_q;
    z_d         = z_q;
    done_d      = 1'b0;
    alu_r       = alu_calc(ALU_SEL, ALU_A, ALU_B, ALU_CIN);
    acc_nxt     = acc_q + (mplier_q[0] ? mcand_q : '0);

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (ALU_SEL == OP_MUL) begin
            state_d  = S_MUL;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, ALU_A};
            mplier_d = ALU_B;
          end else begin
            c_d    = alu_r[WIDTH];
            z_d    = (alu_r[WIDTH-1:0] == '0);
            done_d = 1'b1;
            // CMP and TEST only touch the flags.
            if (ALU_SEL != OP_CMP && ALU_SEL != OP_TEST) begin
              result_d    = alu_r[WIDTH-1:0];
              result_hi_d = '0;
            end
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_nxt;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d     = S_IDLE;
          result_d    = acc_nxt[WIDTH-1:0];
          result_hi_d = acc_nxt[2*WIDTH-1:WIDTH];
          c_d         = (acc_nxt[2*WIDTH-1:WIDTH] != '0);
          z_d         = (acc_nxt == '0);
          done_d      = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      c_q         <= 1'b0;
      z_q         <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      c_q         <= c_d;
      z_q         <= z_d;
      done_q      <= done_d;
    end
  end

  assign ALU_BUSY      = (state_q == S_MUL);
  assign ALU_DONE      = done_q;
  assign ALU_RESULT    = result_q;
  assign ALU_RESULT_HI = result_hi_q;
  assign ALU_C         = c_q;
  assign ALU_Z         = z_q;

endmodule

// File: tb/tb_seq_arith_logic_unit.sv
// Scoreboard bench for seq_arith_logic_unit: an 8-bit instance checked against a
// behavioural model and a 16-bit instance checked against fixed shift vectors.
module tb_seq_arith_logic_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       st8, cin8, busy8, done8, c8, z8;
  logic [7:0] a8, b8, res8, hi8;
  logic [3:0] sel8;

  logic        st16, cin16, busy16, done16, c16, z16;
  logic [15:0] a16, b16, res16, hi16;
  logic [3:0]  sel16;

  seq_arith_logic_unit #(.WIDTH(8)) dut8 (
    .CLK(clk), .RST_N(rst_n), .ALU_START(st8), .ALU_A(a8), .ALU_B(b8),
    .ALU_SEL(sel8), .ALU_CIN(cin8), .ALU_BUSY(busy8), .ALU_DONE(done8),
    .ALU_RESULT(res8), .ALU_RESULT_HI(hi8), .ALU_C(c8), .ALU_Z(z8)
  );

  seq_arith_logic_unit #(.WIDTH(16)) dut16 (
    .CLK(clk), .RST_N(rst_n), .ALU_START(st16), .ALU_A(a16), .ALU_B(b16),
    .ALU_SEL(sel16), .ALU_CIN(cin16), .ALU_BUSY(busy16), .ALU_DONE(done16),
    .ALU_RESULT(res16), .ALU_RESULT_HI(hi16), .ALU_C(c16), .ALU_Z(z16)
  );

  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic        c;
    logic        z;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   bc8   = 0;
  logic [7:0] m_res, m_hi;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (busy8) bc8++;

  always @(negedge clk) begin : mon8
    exp_t e;
    if (rst_n && done8) begin
      if (q8.size() == 0) check_eq("spurious_done8", 32'd1, 32'd0);
      else begin
        e = q8.pop_front();
        check_eq("res8", {24'd0, res8}, e.res);
        check_eq("hi8", {24'd0, hi8}, e.hi);
        check_eq("c8", {31'd0, c8}, {31'd0, e.c});
        check_eq("z8", {31'd0, z8}, {31'd0, e.z});
      end
    end
  end

  always @(negedge clk) begin : mon16
    exp_t e;
    if (rst_n && done16) begin
      if (q16.size() == 0) check_eq("spurious_done16", 32'd1, 32'd0);
      else begin
        e = q16.pop_front();
        check_eq("res16", {16'd0, res16}, e.res);
        check_eq("hi16", {16'd0, hi16}, e.hi);
        check_eq("c16", {31'd0, c16}, {31'd0, e.c});
        check_eq("z16", {31'd0, z16}, {31'd0, e.z});
      end
    end
  end

  // Caller is positioned on a negedge; returns on the negedge after the start edge.
  task automatic issue8(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input bit accept);
    exp_t e;
    int   t;
    logic [7:0] r, tr;
    logic c;
    check_eq("ready8", {31'd0, busy8}, {31'd0, !accept});
    if (accept) begin
      r = m_res; e.hi = {24'd0, m_hi}; c = 1'b0; t = 0; tr = 8'h00;
      case (sel)
        4'd0:  begin t = a + b;       c = (t > 255); r = t[7:0]; end
        4'd1:  begin t = a + b + cin; c = (t > 255); r = t[7:0]; end
        4'd2:  begin t = a - b;       c = (t < 0);   r = t[7:0]; end
        4'd3:  begin t = a - b - cin; c = (t < 0);   r = t[7:0]; end
        4'd4:  begin t = a - b;       c = (t < 0);   tr = t[7:0]; end
        4'd5:  r = a & b;
        4'd6:  r = a | b;
        4'd7:  r = a ^ b;
        4'd8:  tr = a & b;
        4'd9:  begin r = {a[6:0], cin}; c = a[7]; end
        4'd10: begin r = {cin, a[7:1]}; c = a[0]; end
        4'd11: begin r = {a[6:0], a[7]}; c = a[7]; end
        4'd12: begin r = {a[0], a[7:1]}; c = a[0]; end
        4'd13: begin r = {a[7], a[7:1]}; c = a[0]; end
        4'd14: begin r = b; c = cin; end
        default: begin
          t = a * b; r = t[7:0]; e.hi = {24'd0, t[15:8]}; c = (t[15:8] != 0);
        end
      endcase
      if (sel == 4'd15) e.z = (t == 0);
      else if (sel == 4'd4 || sel == 4'd8) e.z = (tr == 8'h00);
      else begin e.z = (r == 8'h00); e.hi = 32'd0; end
      e.res = {24'd0, r};
      e.c = c;
      q8.push_back(e);
      m_res = r;
      m_hi = e.hi[7:0];
    end
    st8 = 1'b1; sel8 = sel; a8 = a; b8 = b; cin8 = cin;
    @(negedge clk);
    st8 = 1'b0; sel8 = 4'($urandom); a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
  endtask

  task automatic issue16(input logic [3:0] sel, input logic [15:0] a, input logic cin,
                         input logic [15:0] er, input logic ec);
    exp_t e;
    e.res = {16'd0, er}; e.hi = 32'd0; e.c = ec; e.z = (er == 16'h0000);
    q16.push_back(e);
    st16 = 1'b1; sel16 = sel; a16 = a; b16 = 16'h5A5A; cin16 = cin;
    @(negedge clk);
    st16 = 1'b0; a16 = 16'($urandom); cin16 = 1'($urandom);
  endtask

  task automatic wait_idle8();
    int n;
    n = 0;
    while (busy8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check_eq("busy8_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    st8 = 1'b0; a8 = '0; b8 = '0; sel8 = '0; cin8 = 1'b0;
    st16 = 1'b0; a16 = '0; b16 = '0; sel16 = '0; cin16 = 1'b0;
    m_res = '0; m_hi = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_res", {24'd0, res8}, 32'd0);
    check_eq("rst_hi", {24'd0, hi8}, 32'd0);
    check_eq("rst_c", {31'd0, c8}, 32'd0);
    check_eq("rst_z", {31'd0, z8}, 32'd0);
    check_eq("rst_busy", {31'd0, busy8}, 32'd0);
    check_eq("rst_done", {31'd0, done8}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue8(4'd0, 8'hFF, 8'h01, 1'b0, 1'b1);
    check_eq("add_busy", {31'd0, busy8}, 32'd0);
    check_eq("add_done", {31'd0, done8}, 32'd1);
    @(negedge clk);
    check_eq("add_done_off", {31'd0, done8}, 32'd0);

    issue8(4'd3, 8'h10, 8'h10, 1'b1, 1'b1);
    issue8(4'd4, 8'h05, 8'h05, 1'b0, 1'b1);
    @(negedge clk);

    bc8 = 0;
    issue8(4'd15, 8'hFF, 8'hFF, 1'b0, 1'b1);
    issue8(4'd0, 8'h11, 8'h22, 1'b0, 1'b0);
    wait_idle8();
    check_eq("mul_busy_cycles", bc8, 32'd8);
    @(negedge clk);
    bc8 = 0;
    issue8(4'd15, 8'h00, 8'h5A, 1'b1, 1'b1);
    wait_idle8();
    check_eq("mul0_busy_cycles", bc8, 32'd8);
    @(negedge clk);

    issue8(4'd15, 8'h03, 8'h05, 1'b0, 1'b1);
    wait_idle8();
    check_eq("b2b_mul_done", {31'd0, done8}, 32'd1);
    issue8(4'd0, 8'h10, 8'h20, 1'b0, 1'b1);
    check_eq("b2b_add_done", {31'd0, done8}, 32'd1);
    @(negedge clk);

    issue8(4'd15, 8'h37, 8'h29, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    q8.delete();
    m_res = '0; m_hi = '0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("abort_res", {24'd0, res8}, 32'd0);
    check_eq("abort_hi", {24'd0, hi8}, 32'd0);
    check_eq("abort_busy", {31'd0, busy8}, 32'd0);
    check_eq("abort_cz", {30'd0, c8, z8}, 32'd0);
    repeat (10) @(negedge clk);
    issue8(4'd0, 8'h01, 8'h01, 1'b0, 1'b1);
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      issue8(4'($urandom_range(0, 14)), 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      issue8(4'd15, 8'($urandom), 8'($urandom), 1'b0, 1'b1);
      wait_idle8();
    end
    @(negedge clk);

    issue16(4'd13, 16'h8001, 1'b0, 16'hC000, 1'b1);
    issue16(4'd11, 16'h8000, 1'b0, 16'h0001, 1'b1);
    issue16(4'd10, 16'h0001, 1'b1, 16'h8000, 1'b1);
    repeat (4) @(negedge clk);

    check_eq("q8_drained", q8.size(), 32'd0);
    check_eq("q16_drained", q16.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
